cva6_l2_tlb_4k_bank: RTL and testbench

- Shared second-level TLB bank for 4 KiB Sv39 leaf translations, filled by the page-table walker.
- Sits between the L1 I/D TLB miss path and the PTW: an L1 miss looks up here first, and the PTW refills here when it completes a walk.
- Set-associative flop storage, tree-PLRU replacement per set, and a sequential flush engine that sweeps one set per cycle.
- Instantiated only when L2 4K TLB support is enabled in the core configuration.

---
 rtl/cva6_l2_tlb_4k_bank.sv | 229 ++++++++++++++++++++++
 tb/tb_cva6_l2_tlb_4k_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_l2_tlb_4k_bank.sv
// Shared L2 TLB bank for 4 KiB Sv39 leaves: set-assoc flops, tree PLRU,
// PTW refill port and a one-set-per-cycle sfence sweep engine.
module cva6_l2_tlb_4k_bank #(
  parameter int unsigned Entries   = 128,
  parameter int unsigned Assoc     = 4,
  parameter int unsigned AsidWidth = 16,
  parameter int unsigned VpnWidth  = 27,
  parameter int unsigned PpnWidth  = 44
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [VpnWidth-1:0]  req_vpn_i,
  input  logic [AsidWidth-1:0] req_asid_i,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic [PpnWidth-1:0]  resp_ppn_o,
  output logic [7:0]           resp_flags_o,
  input  logic                 refill_valid_i,
  input  logic [VpnWidth-1:0]  refill_vpn_i,
  input  logic [AsidWidth-1:0] refill_asid_i,
  input  logic [PpnWidth-1:0]  refill_ppn_i,
  input  logic [7:0]           refill_flags_i,
  input  logic                 flush_i,
  input  logic                 flush_asid_en_i,
  input  logic [AsidWidth-1:0] flush_asid_i,
  input  logic                 flush_vpn_en_i,
  input  logic [VpnWidth-1:0]  flush_vpn_i,
  output logic                 flush_busy_o
);

  localparam int unsigned Sets = Entries / Assoc;
  localparam int unsigned IdxW = $clog2(Sets);
  localparam int unsigned TagW = VpnWidth - IdxW;
  localparam int unsigned WayW = 2;
  localparam int unsigned GBit = 5;

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        cnt_q, cnt_d;
  logic                   fl_aen_q, fl_aen_d;
  logic                   fl_ven_q, fl_ven_d;
  logic [AsidWidth-1:0]   fl_asid_q, fl_asid_d;
  logic [VpnWidth-1:0]    fl_vpn_q, fl_vpn_d;

  logic [Assoc-1:0]       valid_q [Sets];
  logic [TagW-1:0]        tag_q   [Sets][Assoc];
  logic [AsidWidth-1:0]   asid_q  [Sets][Assoc];
  logic [PpnWidth-1:0]    ppn_q   [Sets][Assoc];
  logic [7:0]             flags_q [Sets][Assoc];
  logic [2:0]             plru_q  [Sets];

  logic                   rsp_v_q, rsp_hit_q;
  logic [PpnWidth-1:0]    rsp_ppn_q;
  logic [7:0]             rsp_flags_q;
  logic [IdxW-1:0]        hs_idx_q;
  logic [WayW-1:0]        hs_way_q;

  // Tree PLRU: bit0 root (0=left pair), bit1 picks in {0,1}, bit2 in {2,3}.
  function automatic logic [WayW-1:0] plru_victim(input logic [2:0] p);
    plru_victim = p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] p,
                                            input logic [WayW-1:0] w);
    plru_touch = p;
    if (!w[1]) begin
      plru_touch[0] = 1'b1;
      plru_touch[1] = ~w[0];
    end else begin
      plru_touch[0] = 1'b0;
      plru_touch[2] = ~w[0];
    end
  endfunction

  logic [IdxW-1:0]  lk_idx, rf_idx, fl_idx;
  logic [TagW-1:0]  lk_tag, rf_tag, fl_tag;
  logic [Assoc-1:0] lk_match, rf_match, fl_hit;
  logic [WayW-1:0]  lk_way, rf_way;
  logic             accept, rf_we;

  assign lk_idx = req_vpn_i[IdxW-1:0];
  assign lk_tag = req_vpn_i[VpnWidth-1:IdxW];
  assign rf_idx = refill_vpn_i[IdxW-1:0];
  assign rf_tag = refill_vpn_i[VpnWidth-1:IdxW];
  assign fl_idx = fl_ven_q ? fl_vpn_q[IdxW-1:0] : cnt_q;
  assign fl_tag = fl_vpn_q[VpnWidth-1:IdxW];

  assign req_ready_o  = (state_q == IDLE);
  assign flush_busy_o = (state_q == SWEEP);
  assign accept       = req_valid_i & req_ready_o;
  assign rf_we        = refill_valid_i & (state_q == IDLE);

  always_comb begin
    lk_way = '0;
    rf_way = plru_victim(plru_q[rf_idx]);
    for (int w = 0; w < Assoc; w++) begin
      lk_match[w] = valid_q[lk_idx][w] &&
                    (tag_q[lk_idx][w] == lk_tag) &&
                    (flags_q[lk_idx][w][GBit] ||
                     (asid_q[lk_idx][w] == req_asid_i));
      rf_match[w] = valid_q[rf_idx][w] &&
                    (tag_q[rf_idx][w] == rf_tag) &&
                    (flags_q[rf_idx][w][GBit] ||
                     (asid_q[rf_idx][w] == refill_asid_i));
      fl_hit[w]   = (!fl_ven_q || (tag_q[fl_idx][w] == fl_tag)) &&
                    (!fl_aen_q || ((asid_q[fl_idx][w] == fl_asid_q) &&
                                   !flags_q[fl_idx][w][GBit]));
    end
    for (int w = Assoc - 1; w >= 0; w--) begin
      if (lk_match[w]) lk_way = WayW'(w);
    end
    // Existing match beats lowest invalid way, which beats the PLRU victim.
    for (int w = Assoc - 1; w >= 0; w--) begin
      if (!valid_q[rf_idx][w]) rf_way = WayW'(w);
    end
    for (int w = Assoc - 1; w >= 0; w--) begin
      if (rf_match[w]) rf_way = WayW'(w);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fl_aen_d  = fl_aen_q;
    fl_ven_d  = fl_ven_q;
    fl_asid_d = fl_asid_q;
    fl_vpn_d  = fl_vpn_q;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d   = SWEEP;
          cnt_d     = '0;
          fl_aen_d  = flush_asid_en_i;
          fl_ven_d  = flush_vpn_en_i;
          fl_asid_d = flush_asid_i;
          fl_vpn_d  = flush_vpn_i;
        end
      end
      SWEEP: begin
        if (flush_i) begin
          cnt_d    = '0;
          fl_aen_d = 1'b0;
          fl_ven_d = 1'b0;
        end else if (fl_ven_q || cnt_q == IdxW'(Sets - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fl_aen_q  <= 1'b0;
      fl_ven_q  <= 1'b0;
      fl_asid_q <= '0;
      fl_vpn_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fl_aen_q  <= fl_aen_d;
      fl_ven_q  <= fl_ven_d;
      fl_asid_q <= fl_asid_d;
      fl_vpn_q  <= fl_vpn_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_v_q     <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_ppn_q   <= '0;
      rsp_flags_q <= '0;
      hs_idx_q    <= '0;
      hs_way_q    <= '0;
    end else begin
      rsp_v_q     <= accept;
      rsp_hit_q   <= accept & (|lk_match);
      rsp_ppn_q   <= (accept & (|lk_match)) ? ppn_q[lk_idx][lk_way] : '0;
      rsp_flags_q <= (accept & (|lk_match)) ? flags_q[lk_idx][lk_way] : '0;
      hs_idx_q    <= lk_idx;
      hs_way_q    <= lk_way;
    end
  end

  assign resp_valid_o = rsp_v_q;
  assign resp_hit_o   = rsp_hit_q;
  assign resp_ppn_o   = rsp_ppn_q;
  assign resp_flags_o = rsp_flags_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < Sets; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < Assoc; w++) begin
          tag_q[s][w]   <= '0;
          asid_q[s][w]  <= '0;
          ppn_q[s][w]   <= '0;
          flags_q[s][w] <= '0;
        end
      end
    end else begin
      if (state_q == SWEEP) begin
        valid_q[fl_idx] <= valid_q[fl_idx] & ~fl_hit;
      end
      if (rsp_hit_q) begin
        plru_q[hs_idx_q] <= plru_touch(plru_q[hs_idx_q], hs_way_q);
      end
      // Issued after the hit update so a same-set refill wins.
      if (rf_we) begin
        valid_q[rf_idx][rf_way] <= 1'b1;
        tag_q[rf_idx][rf_way]   <= rf_tag;
        asid_q[rf_idx][rf_way]  <= refill_asid_i;
        ppn_q[rf_idx][rf_way]   <= refill_ppn_i;
        flags_q[rf_idx][rf_way] <= refill_flags_i;
        plru_q[rf_idx]          <= plru_touch(plru_q[rf_idx], rf_way);
      end
    end
  end

endmodule

// File: tb/tb_cva6_l2_tlb_4k_bank.sv
// Directed bench for cva6_l2_tlb_4k_bank: lookups, refills, PLRU eviction,
// full/ASID/VPN flushes, flush restart and reset mid-sweep.
module tb_cva6_l2_tlb_4k_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [26:0] req_vpn;
  logic [15:0] req_asid;
  logic        resp_valid;
  logic        resp_hit;
  logic [43:0] resp_ppn;
  logic [7:0]  resp_flags;
  logic        rf_valid;
  logic [26:0] rf_vpn;
  logic [15:0] rf_asid;
  logic [43:0] rf_ppn;
  logic [7:0]  rf_flags;
  logic        flush;
  logic        fl_aen;
  logic [15:0] fl_asid;
  logic        fl_ven;
  logic [26:0] fl_vpn;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        hit;
    logic [43:0] ppn;
    logic [7:0]  flags;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cva6_l2_tlb_4k_bank dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_vpn_i       (req_vpn),
    .req_asid_i      (req_asid),
    .resp_valid_o    (resp_valid),
    .resp_hit_o      (resp_hit),
    .resp_ppn_o      (resp_ppn),
    .resp_flags_o    (resp_flags),
    .refill_valid_i  (rf_valid),
    .refill_vpn_i    (rf_vpn),
    .refill_asid_i   (rf_asid),
    .refill_ppn_i    (rf_ppn),
    .refill_flags_i  (rf_flags),
    .flush_i         (flush),
    .flush_asid_en_i (fl_aen),
    .flush_asid_i    (fl_asid),
    .flush_vpn_en_i  (fl_ven),
    .flush_vpn_i     (fl_vpn),
    .flush_busy_o    (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic lookup(input logic [26:0] vpn, input logic [15:0] asid,
                        input logic hit, input logic [43:0] ppn,
                        input logic [7:0] fl, input string tag);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_vpn   = vpn;
    req_asid  = asid;
    e.hit   = hit;
    e.ppn   = hit ? ppn : 44'h0;
    e.flags = hit ? fl : 8'h0;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, " resp_valid"}, resp_valid, 1);
    e = sb.pop_front();
    check({tag, " hit"}, resp_hit, e.hit);
    check({tag, " ppn"}, resp_ppn, e.ppn);
    check({tag, " flags"}, resp_flags, e.flags);
    @(negedge clk);
    check({tag, " pulse"}, resp_valid, 0);
  endtask

  task automatic refill(input logic [26:0] vpn, input logic [15:0] asid,
                        input logic [43:0] ppn, input logic [7:0] fl);
    @(negedge clk);
    rf_valid = 1'b1;
    rf_vpn   = vpn;
    rf_asid  = asid;
    rf_ppn   = ppn;
    rf_flags = fl;
    @(negedge clk);
    rf_valid = 1'b0;
  endtask

  task automatic do_flush(input logic aen, input logic [15:0] asid,
                          input logic ven, input logic [26:0] vpn,
                          input int restart_at, input logic rf_in_busy,
                          input int exp_busy, input string tag);
    int   nb;
    logic rdy_ok;
    @(negedge clk);
    flush   = 1'b1;
    fl_aen  = aen;
    fl_asid = asid;
    fl_ven  = ven;
    fl_vpn  = vpn;
    @(negedge clk);
    flush  = 1'b0;
    nb     = 0;
    rdy_ok = 1'b1;
    while (busy === 1'b1 && nb < 200) begin
      if (req_ready !== 1'b0) rdy_ok = 1'b0;
      flush    = (nb == restart_at);
      rf_valid = rf_in_busy && (nb == 0);
      rf_vpn   = 27'h123;
      rf_asid  = 16'd1;
      rf_ppn   = 44'h777;
      rf_flags = 8'hCF;
      nb++;
      @(negedge clk);
    end
    flush    = 1'b0;
    rf_valid = 1'b0;
    check({tag, " busy cycles"}, nb, exp_busy);
    check({tag, " ready low"}, rdy_ok, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_vpn   = '0;
    req_asid  = '0;
    rf_valid  = 1'b0;
    rf_vpn    = '0;
    rf_asid   = '0;
    rf_ppn    = '0;
    rf_flags  = '0;
    flush     = 1'b0;
    fl_aen    = 1'b0;
    fl_asid   = '0;
    fl_ven    = 1'b0;
    fl_vpn    = '0;
    repeat (3) @(negedge clk);
    check("rst resp_valid", resp_valid, 0);
    check("rst resp_hit", resp_hit, 0);
    check("rst resp_ppn", resp_ppn, 0);
    check("rst resp_flags", resp_flags, 0);
    check("rst busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after rst", req_ready, 1);

    lookup(27'h123, 16'd1, 0, 0, 0, "cold miss");
    check("ready idle", req_ready, 1);

    refill(27'h123, 16'd1, 44'h80042, 8'hCF);
    lookup(27'h123, 16'd1, 1, 44'h80042, 8'hCF, "hit a1");
    lookup(27'h123, 16'd2, 0, 0, 0, "miss a2");
    refill(27'h123, 16'd1, 44'h80042, 8'hEF);
    lookup(27'h123, 16'd2, 1, 44'h80042, 8'hEF, "global a2");

    do_flush(0, 0, 0, 0, -1, 0, 32, "full flush");
    lookup(27'h123, 16'd2, 0, 0, 0, "full global");
    lookup(27'h123, 16'd1, 0, 0, 0, "full a1");

    refill(27'h03, 16'd1, 44'h1000, 8'hCF);
    refill(27'h23, 16'd1, 44'h1001, 8'hCF);
    refill(27'h43, 16'd1, 44'h1002, 8'hCF);
    refill(27'h63, 16'd1, 44'h1003, 8'hCF);
    lookup(27'h03, 16'd1, 1, 44'h1000, 8'hCF, "set3 touch 03");
    lookup(27'h43, 16'd1, 1, 44'h1002, 8'hCF, "set3 touch 43");
    refill(27'h83, 16'd1, 44'h1004, 8'hCF);
    lookup(27'h23, 16'd1, 0, 0, 0, "evict 23");
    lookup(27'h03, 16'd1, 1, 44'h1000, 8'hCF, "keep 03");
    lookup(27'h43, 16'd1, 1, 44'h1002, 8'hCF, "keep 43");
    lookup(27'h63, 16'd1, 1, 44'h1003, 8'hCF, "keep 63");
    lookup(27'h83, 16'd1, 1, 44'h1004, 8'hCF, "new 83");

    refill(27'h10, 16'd1, 44'h2000, 8'hCF);
    refill(27'h11, 16'd2, 44'h2001, 8'hCF);
    refill(27'h12, 16'd3, 44'h2002, 8'hEF);
    do_flush(1, 16'd1, 0, 0, -1, 0, 32, "asid flush");
    lookup(27'h10, 16'd1, 0, 0, 0, "asid1 gone");
    lookup(27'h11, 16'd2, 1, 44'h2001, 8'hCF, "asid2 kept");
    lookup(27'h12, 16'd5, 1, 44'h2002, 8'hEF, "global kept");

    do_flush(1, 16'd2, 0, 0, 10, 0, 43, "restart flush");
    lookup(27'h11, 16'd2, 0, 0, 0, "restart asid2");
    lookup(27'h12, 16'd5, 0, 0, 0, "restart global");

    refill(27'h123, 16'd1, 44'h80042, 8'hCF);
    refill(27'h124, 16'd1, 44'h80043, 8'hCF);
    do_flush(0, 0, 1, 27'h123, -1, 1, 1, "vpn flush");
    lookup(27'h123, 16'd1, 0, 0, 0, "vpn gone");
    lookup(27'h124, 16'd1, 1, 44'h80043, 8'hCF, "vpn other");

    @(negedge clk);
    flush  = 1'b1;
    fl_aen = 1'b0;
    fl_ven = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    check("midsweep busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check("midsweep rst busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midsweep ready", req_ready, 1);
    lookup(27'h124, 16'd1, 0, 0, 0, "midsweep miss");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
